// File: rtl/keypad_scanner.sv
// 3x4 matrix keypad scanner: column strobe, row synchronizer, ghost
// rejection and per-scan debounce feeding a registered key code.
module keypad_scanner #(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [2:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_press
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_N   = CW'(DEBOUNCE_SCANS);
   localparam logic [CW-1:0] ONE     = CW'(1);
   localparam logic [3:0]    NONE    = 4'hF;

   typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;

   logic [3:0]    row_s1, row_s2;
   logic [3:0]    samp0, samp1;
   logic [DW-1:0] div;
   logic [1:0]    idx;
   logic [3:0]    res;
   logic          res_vld;
   state_t        state;
   logic [3:0]    key;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;

   assign cnt_inc = cnt + ONE;

   // Bit index is col*4 + row.
   function automatic logic [3:0] key_map(input int i);
      logic [3:0] c;
      case (i)
         0:       c = 4'h1;
         1:       c = 4'h4;
         2:       c = 4'h7;
         3:       c = 4'hA;
         4:       c = 4'h2;
         5:       c = 4'h5;
         6:       c = 4'h8;
         7:       c = 4'h0;
         8:       c = 4'h3;
         9:       c = 4'h6;
         10:      c = 4'h9;
         default: c = 4'hB;
      endcase
      return c;
   endfunction

   // Any scan with more than one closed contact is treated as no key.
   function automatic logic [3:0] decode(input logic [11:0] rows);
      logic [11:0] lows;
      logic [3:0]  c;
      int          n;
      lows = ~rows;
      c    = NONE;
      n    = 0;
      for (int i = 0; i < 12; i++) begin
         if (lows[i]) begin
            n = n + 1;
            c = key_map(i);
         end
      end
      if (n != 1) c = NONE;
      return c;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_s1  <= 4'hF;
         row_s2  <= 4'hF;
         samp0   <= 4'hF;
         samp1   <= 4'hF;
         div     <= '0;
         idx     <= 2'd0;
         col     <= 3'b110;
         res     <= NONE;
         res_vld <= 1'b0;
      end else begin
         row_s1  <= row;
         row_s2  <= row_s1;
         res_vld <= 1'b0;
         if (div == DIV_MAX) begin
            div <= '0;
            case (idx)
               2'd0: begin
                  samp0 <= row_s2;
                  idx   <= 2'd1;
                  col   <= 3'b101;
               end
               2'd1: begin
                  samp1 <= row_s2;
                  idx   <= 2'd2;
                  col   <= 3'b011;
               end
               default: begin
                  res     <= decode({row_s2, samp1, samp0});
                  res_vld <= 1'b1;
                  idx     <= 2'd0;
                  col     <= 3'b110;
               end
            endcase
         end else begin
            div <= div + DW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         key       <= NONE;
         cnt       <= '0;
         key_code  <= NONE;
         key_valid <= 1'b0;
         key_press <= 1'b0;
      end else begin
         key_press <= 1'b0;
         if (res_vld) begin
            case (state)
               IDLE: begin
                  if (res != NONE) begin
                     key <= res;
                     if (ONE >= DEB_N) begin
                        state     <= HELD;
                        cnt       <= '0;
                        key_code  <= res;
                        key_valid <= 1'b1;
                        key_press <= 1'b1;
                     end else begin
                        state <= CONFIRM;
                        cnt   <= ONE;
                     end
                  end
               end
               CONFIRM: begin
                  if (res == key) begin
                     if (cnt_inc >= DEB_N) begin
                        state     <= HELD;
                        cnt       <= '0;
                        key_code  <= key;
                        key_valid <= 1'b1;
                        key_press <= 1'b1;
                     end else begin
                        cnt <= cnt_inc;
                     end
                  end else if (res == NONE) begin
                     state <= IDLE;
                     cnt   <= '0;
                  end else begin
                     key <= res;
                     cnt <= ONE;
                  end
               end
               HELD: begin
                  if (res != key) begin
                     if (ONE >= DEB_N) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        key_code  <= NONE;
                        key_valid <= 1'b0;
                     end else begin
                        state <= RELEASE;
                        cnt   <= ONE;
                     end
                  end
               end
               default: begin
                  if (res == key) begin
                     state <= HELD;
                     cnt   <= '0;
                  end else if (cnt_inc >= DEB_N) begin
                     state     <= IDLE;
                     cnt       <= '0;
                     key_code  <= NONE;
                     key_valid <= 1'b0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 3-column × 4-row matrix keypad, synchronizes and debounces the row returns, and emits a registered 4-bit key code for the 7-segment driver directly downstream. Code 4'hF means "no key" and is the driver's blank code, so an idle keypad blanks the digit. Also provides a key-held flag and a one-cycle press strobe for downstream logic.

## Interface
- SCAN_DIV, default 100000: clk cycles each column is driven (1 ms at 100 MHz); legal range ≥ 4.
- DEBOUNCE_SCANS, default 4: consecutive identical full-scan results required to accept a press or a release; legal range ≥ 1.

- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- row  in  4  keypad row returns, active-low (pulled up off-chip); row[0] = top row.
- col  out  3  column drives, active-low, exactly one low at any time; col[0] = left column.
- key_code  out  4  debounced key code; 4'hF when no key.
- key_valid  out  1  high while a debounced key is held.
- key_press  out  1  one-cycle pulse when a new key is accepted.

## Operation
- Key map (col, row) → code:
  - col0: 1, 4, 7, * → 1, 4, 7, 4'hA.
  - col1: 2, 5, 8, 0 → 2, 5, 8, 0.
  - col2: 3, 6, 9, # → 3, 6, 9, 4'hB.
- Divider counts 0..SCAN_DIV-1. At terminal count:
  - the synchronized row is sampled for the current column;
  - the column index advances 0→1→2→0;
  - col = ~(one-hot index).
- row passes through a 2-flop synchronizer (reset value 4'hF) before use.
- Scan result is formed at the column-2 sample; one full scan takes 3·SCAN_DIV cycles:
  - exactly one low row bit across all three columns → that key's code;
  - zero low bits → NONE;
  - more than one low bit (any mix of columns and rows) → NONE (ghost/multi-key rejection).
- Debounce FSM, evaluated once per scan result; cnt saturates at DEBOUNCE_SCANS; K is the candidate or held key:
  - IDLE: result key R → CONFIRM, K=R, cnt=1. NONE → stay.
  - CONFIRM:
    - result == K → cnt+1; when cnt reaches DEBOUNCE_SCANS → HELD, key_code=K, key_valid=1, key_press=1.
    - other key R → restart with K=R, cnt=1.
    - NONE → IDLE.
  - HELD:
    - result == K → stay.
    - anything else (NONE or another key) → RELEASE, cnt=1.
  - RELEASE:
    - result == K → HELD, cnt cleared.
    - result != K → cnt+1; at DEBOUNCE_SCANS → IDLE, key_code=4'hF, key_valid=0.
  - Another key seen during RELEASE counts as "not K". It is not captured; it must re-confirm from IDLE.
- DEBOUNCE_SCANS=1: CONFIRM and RELEASE each resolve on the scan that enters them, i.e. a single matching result accepts/releases immediately.
- key_press fires only on the IDLE/CONFIRM→HELD transition, never on re-entry to HELD from RELEASE.

## Timing
- Reset values (take effect immediately on rst, no clock needed):
  - col = 3'b110, divider = 0, column index = 0, FSM = IDLE, cnt = 0;
  - key_code = 4'hF, key_valid = 0, key_press = 0.
- First column advance occurs SCAN_DIV cycles after rst deasserts.
- key_code, key_valid and key_press change together, one cycle after the clk edge on which the deciding column-2 sample is taken. They are registered, not combinational from row.
- Press latency for a clean, stable press: at most (DEBOUNCE_SCANS+1)·3·SCAN_DIV + 3 cycles. Release latency has the same bound.
- key_press is high for exactly one cycle per accepted key. A held key never re-strobes.
- rst mid-operation discards any in-progress CONFIRM/RELEASE. A key still held after rst must fully re-confirm and produces one key_press.
- Row settling: the synchronizer adds 2 cycles. Since SCAN_DIV ≥ 4, the sample at terminal count always reflects the current column.

## Test plan
Use SCAN_DIV=4, DEBOUNCE_SCANS=3 (scan = 12 cycles). The keypad model drives row combinationally from col.
- Reset and scan:
  - assert rst mid-run → outputs at reset values with no clock edge;
  - after release, col cycles 110→101→011 every 4 cycles.
- Press key 5 (col1, row1):
  - within 4·12+3 cycles: key_code=5, key_valid=1, single-cycle key_press;
  - hold 10 more scans → no further key_press.
- Bounce: key 5 toggles pressed/released on alternate scans for 8 scans → key_press never fires, key_code stays 4'hF.
- Release after a held 5:
  - key_code stays 5 for two NONE scans and returns to 4'hF after the third; key_valid=0 at the same cycle;
  - a one-scan release glitch → stays 5 with no key_press.
- Multi-key and specials:
  - keys 1 and 3 held together → code stays 4'hF;
  - * alone → 4'hA with key_press; # alone → 4'hB with key_press.
- Reset mid-confirm: key 8 held, rst pulsed after 2 scans → outputs reset; key_code=8 only after 3 full scans post-reset, with one key_press.
